// File: rtl/sdram_chip_model.sv
// Cycle-level SDRAM device model: decodes controller pin commands, tracks open rows and the
// mode register, serves read/write bursts from an internal array and flags protocol errors.
module sdram_chip_model #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 13,
   parameter int BA_W     = 2,
   parameter int COL_W    = 9,
   parameter int ROW_USED = 4
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              sdram_cke,
   input  logic              sdram_cs_n,
   input  logic              sdram_ras_n,
   input  logic              sdram_cas_n,
   input  logic              sdram_we_n,
   input  logic [BA_W-1:0]   sdram_ba,
   input  logic [ADDR_W-1:0] sdram_addr,
   inout  wire  [DATA_W-1:0] sdram_data,
   output logic              model_init_done,
   output logic              model_err,
   output logic [2:0]        model_err_code,
   output logic              model_rd_active
);
   localparam int NBANK  = 1 << BA_W;
   localparam int MEM_AW = BA_W + ROW_USED + COL_W;

   typedef enum logic [2:0] {
      CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
      CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
   } cmd_e;
   typedef enum logic { BANK_IDLE, BANK_ACTIVE } bank_e;
   typedef enum logic [2:0] {
      INIT_WAIT_PALL, INIT_WAIT_REF1, INIT_WAIT_REF2, INIT_WAIT_LMR, INIT_DONE
   } init_e;

   cmd_e                cmd;
   bank_e               bank_q [NBANK];
   bank_e               bank_d [NBANK];
   logic [ROW_USED-1:0] row_q  [NBANK];
   init_e               init_q, init_d;
   logic                any_open, sel_open, rw_cmd, rw_ok, pre_hits_burst;
   logic                bl_ok, cl_ok, new_full;
   logic [COL_W-1:0]    new_mask;
   logic [2:0]          err_now;

   logic [COL_W-1:0]    mode_mask;
   logic                mode_full, mode_cl3;

   logic                bst_active, bst_rd, bst_full;
   logic [BA_W-1:0]     bst_ba;
   logic [ROW_USED-1:0] bst_row;
   logic [COL_W-1:0]    bst_start, bst_idx, bst_mask, bst_col;

   logic                iss_valid, iss_rd;
   logic [MEM_AW-1:0]   iss_addr;
   logic                p0_v, p1_v, out_v;
   logic [MEM_AW-1:0]   p0_a, p1_a;
   logic [DATA_W-1:0]   out_d;
   logic [DATA_W-1:0]   mem [1 << MEM_AW];

   wire unused_addr = ^{sdram_addr[ADDR_W-1:11], sdram_addr[9]};

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      cmd = (!sdram_cke || sdram_cs_n) ? CMD_NOP : cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});
      any_open = 1'b0;
      for (int b = 0; b < NBANK; b++)
         if (bank_q[b] == BANK_ACTIVE) any_open = 1'b1;
      sel_open       = (bank_q[sdram_ba] == BANK_ACTIVE);
      rw_cmd         = (cmd == CMD_RD) || (cmd == CMD_WR);
      rw_ok          = rw_cmd && sel_open;
      pre_hits_burst = (cmd == CMD_PRE) && (sdram_addr[10] || sdram_ba == bst_ba);
   end

   always_comb begin
      bl_ok    = 1'b1;
      new_full = 1'b0;
      new_mask = '0;
      case (sdram_addr[2:0])
         3'b000:  new_mask = COL_W'(0);
         3'b001:  new_mask = COL_W'(1);
         3'b010:  new_mask = COL_W'(3);
         3'b011:  new_mask = COL_W'(7);
         3'b111:  begin new_mask = '1; new_full = 1'b1; end
         default: bl_ok = 1'b0;
      endcase
      cl_ok = (sdram_addr[6:4] == 3'b010) || (sdram_addr[6:4] == 3'b011);
   end

   always_comb begin
      bank_d = bank_q;
      case (cmd)
         CMD_ACT: bank_d[sdram_ba] = BANK_ACTIVE;
         CMD_PRE:
            for (int b = 0; b < NBANK; b++)
               if (sdram_addr[10] || sdram_ba == BA_W'(b)) bank_d[b] = BANK_IDLE;
         default: ;
      endcase
   end

   always_comb begin
      init_d = init_q;
      case (init_q)
         INIT_WAIT_PALL: if (cmd == CMD_PRE && sdram_addr[10]) init_d = INIT_WAIT_REF1;
         INIT_WAIT_REF1: if (cmd == CMD_REF) init_d = INIT_WAIT_REF2;
         INIT_WAIT_REF2: if (cmd == CMD_REF) init_d = INIT_WAIT_LMR;
         INIT_WAIT_LMR:  if (cmd == CMD_LMR && bl_ok && cl_ok) init_d = INIT_DONE;
         default: ;
      endcase
   end

   assign model_init_done = (init_q == INIT_DONE);

   always_comb begin
      err_now = 3'd0;
      case (cmd)
         CMD_ACT:         if (!model_init_done) err_now = 3'd4; else if (sel_open) err_now = 3'd1;
         CMD_RD, CMD_WR:  if (!model_init_done) err_now = 3'd4; else if (!sel_open) err_now = 3'd2;
         CMD_REF:         if (any_open) err_now = 3'd3;
         CMD_LMR:         if (any_open) err_now = 3'd5; else if (!(bl_ok && cl_ok)) err_now = 3'd6;
         default: ;
      endcase
   end

   // Word i of a burst sits at the BL-aligned block base plus (start + i) modulo BL.
   assign bst_col = (bst_start & ~bst_mask) | ((bst_start + bst_idx) & bst_mask);

   always_comb begin
      iss_valid = 1'b0;
      iss_rd    = 1'b0;
      iss_addr  = '0;
      if (rw_ok) begin
         iss_valid = 1'b1;
         iss_rd    = (cmd == CMD_RD);
         iss_addr  = {sdram_ba, row_q[sdram_ba], sdram_addr[COL_W-1:0]};
      end else if (sdram_cke && bst_active && !rw_cmd && cmd != CMD_BST && !pre_hits_burst) begin
         iss_valid = 1'b1;
         iss_rd    = bst_rd;
         iss_addr  = {bst_ba, bst_row, bst_col};
      end
   end

   // NOTE: all sequential state is updated with non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NBANK; b++) begin
            bank_q[b] <= BANK_IDLE;
            row_q[b]  <= '0;
         end
         init_q         <= INIT_WAIT_PALL;
         model_err      <= 1'b0;
         model_err_code <= 3'd0;
         mode_mask      <= '0;
         mode_full      <= 1'b0;
         mode_cl3       <= 1'b1;
      end else begin
         bank_q <= bank_d;
         init_q <= init_d;
         if (cmd == CMD_ACT) row_q[sdram_ba] <= sdram_addr[ROW_USED-1:0];
         if (err_now != 3'd0 && !model_err) begin
            model_err      <= 1'b1;
            model_err_code <= err_now;
         end
         if (cmd == CMD_LMR && bl_ok && cl_ok) begin
            mode_mask <= new_mask;
            mode_full <= new_full;
            mode_cl3  <= sdram_addr[4];
         end
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         bst_active <= 1'b0;
         bst_rd     <= 1'b0;
         bst_full   <= 1'b0;
         bst_ba     <= '0;
         bst_row    <= '0;
         bst_start  <= '0;
         bst_idx    <= '0;
         bst_mask   <= '0;
      end else if (sdram_cke) begin
         if (rw_ok) begin
            bst_active <= (mode_mask != '0);
            bst_rd     <= (cmd == CMD_RD);
            bst_full   <= mode_full;
            bst_ba     <= sdram_ba;
            bst_row    <= row_q[sdram_ba];
            bst_start  <= sdram_addr[COL_W-1:0];
            bst_idx    <= COL_W'(1);
            bst_mask   <= mode_mask;
         end else if (rw_cmd || cmd == CMD_BST || pre_hits_burst) begin
            bst_active <= 1'b0;
         end else if (bst_active) begin
            bst_idx <= bst_idx + COL_W'(1);
            if (!bst_full && bst_idx == bst_mask) bst_active <= 1'b0;
         end
      end
   end

   // Read pipeline: issue stage, optional CL3 stage, output register; a WRITE flushes it.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         p0_v  <= 1'b0;
         p1_v  <= 1'b0;
         out_v <= 1'b0;
         p0_a  <= '0;
         p1_a  <= '0;
         out_d <= '0;
      end else if (sdram_cke) begin
         if (cmd == CMD_WR) begin
            p0_v  <= 1'b0;
            p1_v  <= 1'b0;
            out_v <= 1'b0;
         end else begin
            p0_v  <= iss_valid && iss_rd;
            p0_a  <= iss_addr;
            p1_v  <= p0_v;
            p1_a  <= p0_a;
            out_v <= mode_cl3 ? p1_v : p0_v;
            out_d <= mem[mode_cl3 ? p1_a : p0_a];
         end
      end
   end

   // NOTE: the array is deliberately left out of reset so its contents survive a reset pulse.
   always_ff @(posedge clk_50m) begin
      if (iss_valid && !iss_rd) mem[iss_addr] <= sdram_data;
   end

   assign sdram_data      = out_v ? out_d : {DATA_W{1'bz}};
   assign model_rd_active = out_v;

endmodule

// File: tb/tb_sdram_chip_model.sv
// Directed bench for sdram_chip_model: stimulus pushes expected read words with their
// sampling cycle into a scoreboard, a negedge monitor pops and compares them.
module tb_sdram_chip_model;
   localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                          C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cke, cs_n, ras_n, cas_n, we_n;
   logic [1:0]  ba;
   logic [12:0] addr;
   logic [15:0] tb_dq;
   logic        tb_drive;
   wire  [15:0] sdram_data;
   logic        init_done, err, rd_active;
   logic [2:0]  err_code;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   assign sdram_data = tb_drive ? tb_dq : 16'hzzzz;

   sdram_chip_model dut (
      .clk_50m        (clk),
      .rst_n          (rst_n),
      .sdram_cke      (cke),
      .sdram_cs_n     (cs_n),
      .sdram_ras_n    (ras_n),
      .sdram_cas_n    (cas_n),
      .sdram_we_n     (we_n),
      .sdram_ba       (ba),
      .sdram_addr     (addr),
      .sdram_data     (sdram_data),
      .model_init_done(init_done),
      .model_err      (err),
      .model_err_code (err_code),
      .model_rd_active(rd_active)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a word sampled here after edge e was registered at e and is valid for edge e+1.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (tb_drive) check("bus_contention", {31'd0, rd_active}, 32'd0);
      if (rd_active) begin
         if (sb.size() == 0) check("rd_unexpected", {31'd0, rd_active}, 32'd0);
         else begin
            e = sb.pop_front();
            check("rd_data", {16'd0, sdram_data}, {16'd0, e.data});
            check("rd_cycle", cyc, e.cyc);
         end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check("rd_missing", {31'd0, rd_active}, 32'd1);
      end
   end

   task automatic drive_cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
      cs_n = 1'b0;
      {ras_n, cas_n, we_n} = c;
      ba   = b;
      addr = a;
   endtask

   task automatic step();
      @(posedge clk);
      #4;
      cs_n = 1'b1;
      {ras_n, cas_n, we_n} = C_NOP;
   endtask

   task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
      drive_cmd(c, b, a);
      step();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // d holds word 0 in bits [15:0]; term issues BURST TERMINATE right after n words.
   task automatic write_burst(input logic [1:0] b, input logic [8:0] col, input logic [63:0] d,
                              input int n, input bit term);
      tb_drive = 1'b1;
      tb_dq    = d[15:0];
      drive_cmd(C_WR, b, {4'd0, col});
      step();
      for (int i = 1; i < n; i++) begin
         tb_dq = d[16*i +: 16];
         step();
      end
      tb_drive = 1'b0;
      if (term) issue(C_BST, 2'd0, 13'd0);
   endtask

   task automatic read_burst(input logic [1:0] b, input logic [8:0] col, input int cl,
                             input logic [63:0] d, input int n, input bit term);
      int k;
      k = cyc + 1;
      for (int i = 0; i < n; i++) sb.push_back('{d[16*i +: 16], k + cl - 1 + i});
      issue(C_RD, b, {4'd0, col});
      if (term) begin
         idle(n - 1);
         issue(C_BST, 2'd0, 13'd0);
      end
   endtask

   task automatic init_seq();
      issue(C_PRE, 2'd0, 13'h400);
      issue(C_REF, 2'd0, 13'd0);
      issue(C_REF, 2'd0, 13'd0);
      check("init_before_lmr", {31'd0, init_done}, 32'd0);
      issue(C_LMR, 2'd0, 13'h032);
      check("init_done", {31'd0, init_done}, 32'd1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
      ba = '0; addr = '0; tb_dq = '0; tb_drive = 1'b0;
      rst_n = 1'b0;
      #10;
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_err_code", {29'd0, err_code}, 32'd0);
      check("rst_rd_active", {31'd0, rd_active}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #4;

      // 1: init sequence, BL=4 CL=3
      init_seq();
      check("init_err", {31'd0, err}, 32'd0);

      // 2: BL=4 block wrap at column 0x1FE
      issue(C_ACT, 2'd0, 13'd5);
      write_burst(2'd0, 9'h1FE, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 4, 1'b0);
      idle(2);
      read_burst(2'd0, 9'h1FE, 3, {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0}, 4, 1'b0);
      idle(8);
      read_burst(2'd0, 9'h1FC, 3, {16'h00A1, 16'h00A0, 16'h00A3, 16'h00A2}, 4, 1'b0);
      idle(8);
      check("t2_drained", sb.size(), 32'd0);

      // 3: full page, CL=2, wrap 511 -> 0
      issue(C_PRE, 2'd0, 13'h400);
      issue(C_LMR, 2'd0, 13'h027);
      check("t3_lmr_err", {31'd0, err}, 32'd0);
      issue(C_ACT, 2'd1, 13'd6);
      write_burst(2'd1, 9'd510, {16'hC001, 16'hC000, 16'hC511, 16'hC510}, 4, 1'b1);
      idle(2);
      read_burst(2'd1, 9'd510, 2, {16'hC001, 16'hC000, 16'hC511, 16'hC510}, 4, 1'b1);
      idle(6);
      check("t3_drained", sb.size(), 32'd0);

      // 4: WRITE one cycle after READ cancels the read before it drives
      issue(C_RD, 2'd1, 13'h010);
      write_burst(2'd1, 9'h020, {32'd0, 16'hE001, 16'hE000}, 2, 1'b1);
      idle(4);
      check("t4_no_drive", {31'd0, rd_active}, 32'd0);
      read_burst(2'd1, 9'h020, 2, {32'd0, 16'hE001, 16'hE000}, 2, 1'b1);
      idle(5);
      check("t4_drained", sb.size(), 32'd0);
      check("t4_err", {31'd0, err}, 32'd0);

      // 5: REFRESH with bank 2 open latches code 3; later errors do not overwrite it
      issue(C_ACT, 2'd2, 13'd1);
      check("t5_act_ok", {31'd0, err}, 32'd0);
      issue(C_REF, 2'd0, 13'd0);
      check("t5_err", {31'd0, err}, 32'd1);
      check("t5_code", {29'd0, err_code}, 32'd3);
      issue(C_ACT, 2'd2, 13'd1);
      check("t5_err_sticky", {31'd0, err}, 32'd1);
      check("t5_code_held", {29'd0, err_code}, 32'd3);

      // 6: reset in the middle of a full-page read
      begin
         int k;
         k = cyc + 1;
         sb.push_back('{16'hE000, k + 1});
         sb.push_back('{16'hE001, k + 2});
         issue(C_RD, 2'd1, 13'h020);
         idle(1);
         @(posedge clk);
         @(negedge clk);
         #2;
         rst_n = 1'b0;
         #1;
         check("t6_rd_active", {31'd0, rd_active}, 32'd0);
         check("t6_init_done", {31'd0, init_done}, 32'd0);
         check("t6_err", {31'd0, err}, 32'd0);
         check("t6_code", {29'd0, err_code}, 32'd0);
         check("t6_drained", sb.size(), 32'd0);
         @(posedge clk);
         #4;
         rst_n = 1'b1;
      end
      init_seq();
      issue(C_ACT, 2'd1, 13'd6);
      check("t6_bank1_idle", {31'd0, err}, 32'd0);
      issue(C_ACT, 2'd0, 13'd5);
      check("t6_bank0_idle", {31'd0, err}, 32'd0);
      read_burst(2'd0, 9'h1FC, 3, {16'h00A1, 16'h00A0, 16'h00A3, 16'h00A2}, 4, 1'b0);
      idle(8);
      check("t6_final_drained", sb.size(), 32'd0);
      check("t6_final_err", {31'd0, err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
